gray_decoder_rx: RTL

//  Receive-side partner of the 4-bit Gray-code counter: samples a Gray-coded count,

---
 rtl/gray_rx_pkg.sv | 23 ++
 rtl/gray2bin_comb.sv | 15 +
 rtl/gray_decoder_rx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gray_rx_pkg.sv
// Shared types and helpers for the Gray-code receive checker: FSM states,
// step classes and a per-bit Gray-to-binary helper.
package gray_rx_pkg;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } gray_rx_state_t;

    localparam logic [1:0] STEP_HOLD = 2'd0;
    localparam logic [1:0] STEP_FWD  = 2'd1;
    localparam logic [1:0] STEP_BWD  = 2'd2;
    localparam logic [1:0] STEP_BAD  = 2'd3;

    localparam int ERR_CNT_W = 8;

    // Binary bit idx is the XOR of all Gray bits at or above idx; callers
    // zero-extend the Gray word so the bits above WIDTH contribute nothing.
    function automatic logic gray2bin(input logic [31:0] g, input int unsigned idx);
        return ^(g >> idx);
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational Gray-to-binary decoder of configurable width.
module gray2bin_comb
    import gray_rx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = gray2bin(32'(gray_i), i);
    end

endmodule

// File: rtl/gray_decoder_rx.sv
// Gray-count link receiver: decodes samples, classifies each step, tracks lock.
// Optional macro GRAY_BIDIR_EN accepts backward steps and adds the dir_down port.
module gray_decoder_rx
    import gray_rx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LOCK_CNT  = 3,
    parameter int ERR_LIMIT = 2
) (
    input  logic                 clk_rx,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 gray_valid,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 step_ok,
    output logic                 step_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef GRAY_BIDIR_EN
    ,
    output logic                 dir_down
`endif
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(ERR_LIMIT + 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  BAD_MAX  = BAD_W'(ERR_LIMIT);
    localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);

    gray_rx_state_t       state_q, state_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic                 hist_q, hist_d;
    logic                 bin_valid_q, bin_valid_d;
    logic                 step_ok_q, step_ok_d;
    logic                 step_err_q, step_err_d;
    logic [GOOD_W-1:0]    good_q, good_d;
    logic [BAD_W-1:0]     bad_q, bad_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
`ifdef GRAY_BIDIR_EN
    logic                 dir_down_q, dir_down_d;
`endif

    logic [WIDTH-1:0] dec_bin;
    logic [1:0]       step_class;
    logic             is_ok, is_err, is_down;

    gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
        .gray_i (gray_in),
        .bin_o  (dec_bin)
    );

    always_comb begin
        if (dec_bin == bin_q)
            step_class = STEP_HOLD;
        else if (dec_bin == bin_q + ONE)
            step_class = STEP_FWD;
        else if (dec_bin == bin_q - ONE)
            step_class = STEP_BWD;
        else
            step_class = STEP_BAD;
    end

    // Without history there is nothing to compare against, so no step pulse.
    always_comb begin
        is_ok   = 1'b0;
        is_err  = 1'b0;
        is_down = 1'b0;
        if (gray_valid && hist_q) begin
            case (step_class)
                STEP_HOLD: ;
                STEP_FWD:  is_ok = 1'b1;
`ifdef GRAY_BIDIR_EN
                STEP_BWD: begin
                    is_ok   = 1'b1;
                    is_down = 1'b1;
                end
`endif
                default:   is_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        hist_d      = hist_q;
        bin_valid_d = 1'b0;
        step_ok_d   = 1'b0;
        step_err_d  = 1'b0;
        good_d      = good_q;
        bad_d       = bad_q;
        err_cnt_d   = err_cnt_q;
`ifdef GRAY_BIDIR_EN
        dir_down_d  = dir_down_q;
`endif
        if (gray_valid) begin
            bin_d       = dec_bin;
            bin_valid_d = 1'b1;
            hist_d      = 1'b1;
        end
        if (is_ok) begin
            step_ok_d = 1'b1;
`ifdef GRAY_BIDIR_EN
            dir_down_d = is_down;
`endif
            if (state_q == ST_UNLOCKED) begin
                if (good_q + GOOD_W'(1) == GOOD_MAX) begin
                    state_d = ST_LOCKED;
                    good_d  = '0;
                    bad_d   = '0;
                end else begin
                    good_d = good_q + GOOD_W'(1);
                end
            end else begin
                bad_d = '0;
            end
        end
        if (is_err) begin
            step_err_d = 1'b1;
            if (err_cnt_q != {ERR_CNT_W{1'b1}})
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            if (state_q == ST_UNLOCKED) begin
                good_d = '0;
            end else if (bad_q + BAD_W'(1) == BAD_MAX) begin
                state_d = ST_UNLOCKED;
                bad_d   = '0;
                good_d  = '0;
            end else begin
                bad_d = bad_q + BAD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_rx or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNLOCKED;
            bin_q       <= '0;
            hist_q      <= 1'b0;
            bin_valid_q <= 1'b0;
            step_ok_q   <= 1'b0;
            step_err_q  <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
            err_cnt_q   <= '0;
`ifdef GRAY_BIDIR_EN
            dir_down_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            hist_q      <= hist_d;
            bin_valid_q <= bin_valid_d;
            step_ok_q   <= step_ok_d;
            step_err_q  <= step_err_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            err_cnt_q   <= err_cnt_d;
`ifdef GRAY_BIDIR_EN
            dir_down_q  <= dir_down_d;
`endif
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = bin_valid_q;
    assign step_ok   = step_ok_q;
    assign step_err  = step_err_q;
    assign locked    = (state_q == ST_LOCKED);
    assign err_cnt   = err_cnt_q;
`ifdef GRAY_BIDIR_EN
    assign dir_down  = dir_down_q;
`endif

endmodule
